// File: rtl/ring_slot_arbiter.sv
// Per-node ring slot scheduler: local delivery, pass-through forwarding,
// outbound injection with a one-entry swap buffer and anti-starvation.
module ring_slot_arbiter #(
    parameter int NODE_ID      = 0,
    parameter int ID_WIDTH     = 2,
    parameter int PACKET_WIDTH = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ring_enable,
    input  logic                    ring_in_valid,
    input  logic [PACKET_WIDTH-1:0] ring_in_packet,
    output logic                    ring_out_valid,
    output logic [PACKET_WIDTH-1:0] ring_out_packet,
    input  logic                    inbound_full,
    output logic                    inbound_put,
    output logic [PACKET_WIDTH-1:0] inbound_data,
    input  logic                    outbound_empty,
    input  logic [PACKET_WIDTH-1:0] outbound_data,
    output logic                    outbound_get,
    output logic                    recirc,
    output logic                    hold_active
);

    typedef enum logic {
        NORMAL,
        HOLD
    } state_t;

    localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(NODE_ID);
    localparam logic [3:0]          LIMIT = 4'(STARVE_LIMIT);

    state_t                  state_q, state_d;
    logic [PACKET_WIDTH-1:0] hold_q, hold_d;
    logic [PACKET_WIDTH-1:0] out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              starve_q, starve_d;

    logic active;
    logic local_hit;
    logic deliver;
    logic free_slot;
    logic has_out;

    assign active    = reset_n && ring_enable;
    assign local_hit = ring_in_valid
                    && (ring_in_packet[ID_WIDTH-1:0] == MY_ID);
    assign deliver   = local_hit && !inbound_full;
    assign free_slot = !ring_in_valid || deliver;
    assign has_out   = !outbound_empty;

    assign inbound_put     = active && deliver;
    assign recirc          = active && local_hit && inbound_full;
    assign inbound_data    = ring_in_packet;
    assign hold_active     = (state_q == HOLD);
    assign ring_out_valid  = out_valid_q;
    assign ring_out_packet = out_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        starve_d     = starve_q;
        outbound_get = 1'b0;
        if (active) begin
            unique case (state_q)
                NORMAL: begin
                    starve_d = '0;
                    if (free_slot) begin
                        out_valid_d = has_out;
                        if (has_out) begin
                            out_d        = outbound_data;
                            outbound_get = 1'b1;
                        end
                    end else if (!has_out) begin
                        out_d       = ring_in_packet;
                        out_valid_d = 1'b1;
                    end else if (starve_q < LIMIT) begin
                        out_d       = ring_in_packet;
                        out_valid_d = 1'b1;
                        starve_d    = starve_q + 4'd1;
                    end else begin
                        // Starved too long: inject and park the transit slot
                        out_d        = outbound_data;
                        out_valid_d  = 1'b1;
                        outbound_get = 1'b1;
                        hold_d       = ring_in_packet;
                        state_d      = HOLD;
                    end
                end
                HOLD: begin
                    out_d       = hold_q;
                    out_valid_d = 1'b1;
                    if (free_slot) begin
                        state_d = NORMAL;
                    end else begin
                        hold_d = ring_in_packet;
                    end
                    if (!has_out) begin
                        starve_d = '0;
                    end else if (starve_q < LIMIT) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = LIMIT;
                    end
                end
                default: begin
                    state_d = NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= NORMAL;
            hold_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            starve_q    <= starve_d;
        end
    end

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// Self-checking bench for ring_slot_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_ring_slot_arbiter;

    localparam int PW    = 64;
    localparam int LIMIT = 4;
    localparam logic [1:0] MY_ID = 2'd0;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ring_enable;
    logic          ring_in_valid;
    logic [PW-1:0] ring_in_packet;
    logic          ring_out_valid;
    logic [PW-1:0] ring_out_packet;
    logic          inbound_full;
    logic          inbound_put;
    logic [PW-1:0] inbound_data;
    logic          outbound_empty;
    logic [PW-1:0] outbound_data;
    logic          outbound_get;
    logic          recirc;
    logic          hold_active;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] m_hold[$];
    int            m_starve;
    logic          m_v;
    logic [PW-1:0] m_pkt;

    logic [2:0]    exp_comb, obs_comb;
    logic [PW-1:0] obs_in_data;
    logic [68:0]   exp_all, obs_all;

    ring_slot_arbiter #(
        .NODE_ID(0),
        .ID_WIDTH(2),
        .PACKET_WIDTH(PW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ring_enable(ring_enable),
        .ring_in_valid(ring_in_valid),
        .ring_in_packet(ring_in_packet),
        .ring_out_valid(ring_out_valid),
        .ring_out_packet(ring_out_packet),
        .inbound_full(inbound_full),
        .inbound_put(inbound_put),
        .inbound_data(inbound_data),
        .outbound_empty(outbound_empty),
        .outbound_data(outbound_data),
        .outbound_get(outbound_get),
        .recirc(recirc),
        .hold_active(hold_active)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_hold.delete();
        m_starve = 0;
        m_v      = 1'b0;
        m_pkt    = '0;
    endtask

    // Drive one cycle, capture DUT outputs and advance the reference model
    task automatic step(input logic en, input logic vin,
                        input logic [PW-1:0] pkt, input logic full,
                        input logic empty, input logic [PW-1:0] od);
        logic hit, dlv, fr, has, inj;
        ring_enable    = en;
        ring_in_valid  = vin;
        ring_in_packet = pkt;
        inbound_full   = full;
        outbound_empty = empty;
        outbound_data  = od;
        #1;
        hit = vin && (pkt[1:0] == MY_ID);
        dlv = hit && !full;
        fr  = !vin || dlv;
        has = !empty;
        inj = 1'b0;
        if (en && m_hold.size() == 0)
            inj = has && (fr || m_starve == LIMIT);
        exp_comb    = en ? {dlv, inj, hit && full} : 3'b000;
        obs_comb    = {inbound_put, outbound_get, recirc};
        obs_in_data = inbound_data;
        @(posedge clock);
        #1;
        if (en) begin
            if (m_hold.size() == 0) begin
                if (fr) begin
                    m_v = inj;
                    if (inj) m_pkt = od;
                    m_starve = 0;
                end else if (inj) begin
                    m_v = 1'b1;
                    m_pkt = od;
                    m_hold.push_back(pkt);
                    m_starve = 0;
                end else begin
                    m_v = 1'b1;
                    m_pkt = pkt;
                    m_starve = has ? m_starve + 1 : 0;
                end
            end else begin
                m_v   = 1'b1;
                m_pkt = m_hold.pop_front();
                if (!fr) m_hold.push_back(pkt);
                if (!has) m_starve = 0;
                else m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end
        end
        exp_all = {exp_comb, m_v, (m_hold.size() != 0),
                   (m_v ? m_pkt : {PW{1'b0}})};
        obs_all = {obs_comb, ring_out_valid, hold_active,
                   (ring_out_valid ? ring_out_packet : {PW{1'b0}})};
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ring_enable    = 1'b1;
        ring_in_valid  = 1'b1;
        ring_in_packet = 64'hA0;
        inbound_full   = 1'b0;
        outbound_empty = 1'b0;
        outbound_data  = 64'hB1;
        #2;
        checks++;
        if ({inbound_put, outbound_get, recirc, ring_out_valid, hold_active} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {inbound_put, outbound_get, recirc, ring_out_valid, hold_active});
        end
        @(posedge clock);
        #1;
        checks++;
        if (ring_out_packet !== 64'h0 || ring_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got %b/%h want 0/0", ring_out_valid, ring_out_packet);
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
            checks++;
            if (obs_all !== 69'h0) begin
                errors++;
                $display("FAIL reset_idle %0d: got %h want 0", i, obs_all);
            end
        end
    endtask

    task automatic test_deliver_inject();
        logic [PW-1:0] pkt, od;
        pkt = 64'h0123_4567_89AB_CDA0;
        od  = 64'hFEDC_BA98_7654_32B1;
        step(1'b1, 1'b1, pkt, 1'b0, 1'b0, od);
        checks++;
        if (obs_in_data !== pkt) begin
            errors++;
            $display("FAIL deliver_data: got %h want %h", obs_in_data, pkt);
        end
        checks++;
        if (obs_all !== {3'b110, 1'b1, 1'b0, od}) begin
            errors++;
            $display("FAIL deliver_inject: got %h want %h", obs_all, {3'b110, 1'b1, 1'b0, od});
        end
    endtask

    task automatic test_forced_swap();
        logic [PW-1:0] od, want;
        logic [2:0]    wc;
        logic          wh;
        od = 64'hB0B0_0000_0000_00B0;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1, PW'(k * 16 + 1), 1'b0, 1'b0, od);
            if (k <= 4) begin
                want = PW'(k * 16 + 1); wc = 3'b000; wh = 1'b0;
            end else if (k == 5) begin
                want = od; wc = 3'b010; wh = 1'b1;
            end else begin
                want = PW'((k - 1) * 16 + 1); wc = 3'b000; wh = 1'b1;
            end
            checks++;
            if (obs_all !== {wc, 1'b1, wh, want}) begin
                errors++;
                $display("FAIL forced_swap %0d: got %h want %h", k, obs_all, {wc, 1'b1, wh, want});
            end
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, od);
        checks++;
        if (obs_all !== {3'b000, 1'b1, 1'b0, PW'(8 * 16 + 1)}) begin
            errors++;
            $display("FAIL forced_drain: got %h want %h", obs_all,
                     {3'b000, 1'b1, 1'b0, PW'(8 * 16 + 1)});
        end
    endtask

    task automatic test_freeze();
        logic [68:0]   frozen;
        logic [PW-1:0] od;
        od = 64'hCAFE_0000_0000_0002;
        for (int k = 0; k < 8 && m_hold.size() == 0; k++) begin
            step(1'b1, 1'b1, PW'(k * 16 + 32'h201), 1'b0, 1'b0, od);
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL freeze_setup %0d: got %h want %h", k, obs_all, exp_all);
            end
        end
        checks++;
        if (hold_active !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold: got %b want 1", hold_active);
        end
        frozen = {3'b000, exp_all[65:0]};
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, {$urandom, $urandom} & ~64'h3, 1'b0, 1'b0, od);
            checks++;
            if (obs_all !== frozen) begin
                errors++;
                $display("FAIL freeze_%0d: got %h want %h", k, obs_all, frozen);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, k < 4, PW'(k * 16 + 32'h301), 1'b0, 1'b0, od);
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL freeze_resume %0d: got %h want %h", k, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_inbound_full();
        logic [PW-1:0] pkt;
        pkt = 64'h5555_0000_0000_00C4;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, pkt, 1'b1, 1'b1, '0);
        checks++;
        if (obs_all !== {3'b001, 1'b1, 1'b0, pkt}) begin
            errors++;
            $display("FAIL inbound_full: got %h want %h", obs_all, {3'b001, 1'b1, 1'b0, pkt});
        end
    endtask

    task automatic test_empty_outbound();
        logic [PW-1:0] od, pkt;
        od = 64'hD00D_0000_0000_0D00;
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        for (int k = 0; k < 15; k++) begin
            pkt = PW'(k * 16 + 32'h402);
            step(1'b1, 1'b1, pkt, 1'b0, k < 10, od);
            checks++;
            if (k < 14 && obs_all !== {3'b000, 1'b1, 1'b0, pkt}) begin
                errors++;
                $display("FAIL empty_fwd %0d: got %h want %h", k, obs_all, {3'b000, 1'b1, 1'b0, pkt});
            end else if (k == 14 && obs_all !== {3'b010, 1'b1, 1'b1, od}) begin
                errors++;
                $display("FAIL empty_force: got %h want %h", obs_all, {3'b010, 1'b1, 1'b1, od});
            end
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
    endtask

    task automatic test_random();
        logic [PW-1:0] pkt;
        for (int i = 0; i < 400; i++) begin
            pkt = {$urandom, $urandom};
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, pkt,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 {$urandom, $urandom});
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL random %0d: got %h want %h", i, obs_all, exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_deliver_inject();
        test_forced_swap();
        test_freeze();
        test_inbound_full();
        test_empty_outbound();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
